mlp_acc_top: RTL and testbench

Eight-layer 16×16 matrix-MLP accelerator at the top of the MLP datapath. It loads a 16×16 signed 16-bit activation matrix once. Each layer then streams in a 16×16 weight matrix and computes Y = act(A × W_L) in outer-product order, feeding the result into the next layer. After layer 7 it exposes the final matrix in parallel and streams it out on a 32-bit result port.

---
 rtl/mlp_acc_top.sv | 127 ++++++++++++
 tb/tb_mlp_acc_top.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_acc_top.sv
// Eight-layer 16x16 matrix MLP: outer-product MACs over streamed weight beats, ReLU/saturate
// between layers, final matrix exposed in parallel and streamed out row-major for 128 cycles.
module mlp_acc_top (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_en_i,
  input  logic [31:0]             load_payload_i,
  input  logic                    load_type_i,
  input  logic [3:0]              input_load_number,
  input  logic [2:0]              layer_number,
  input  logic [2:0]              weight_number,
  output logic                    result_valid_o,
  output logic [31:0]             result_payload_o,
  output logic [15:0][15:0][15:0] out_reg_c
);

  typedef enum logic {IDLE, STREAM} rd_state_t;

  logic signed [15:0] act_q [16][16];
  logic signed [35:0] acc_q [16][16];
  logic [2:0]         beat_j;
  rd_state_t          state_q, state_d;
  logic [6:0]         cnt_q, cnt_d;

  logic signed [15:0] wt   [2];
  logic [3:0]         col  [2];
  logic signed [31:0] prod [16][2];
  logic signed [35:0] sum  [16][2];
  logic               act_beat, weight_beat, trigger;

  assign act_beat    = load_en_i & load_type_i;
  assign weight_beat = load_en_i & ~load_type_i;
  assign trigger     = weight_beat & (layer_number == 3'd7) &
                       (input_load_number == 4'd15) & (weight_number == 3'd7);

  assign wt[0]  = load_payload_i[15:0];
  assign wt[1]  = load_payload_i[31:16];
  assign col[0] = {weight_number, 1'b0};
  assign col[1] = {weight_number, 1'b1};

  function automatic logic signed [15:0] act_fn(input logic signed [35:0] x);
    if (x < 36'sd0)
      return 16'sd0;
    else if (x > 36'sd32767)
      return 16'sd32767;
    else
      return x[15:0];
  endfunction

  // Step 0 starts from the bare product, which clears the accumulator implicitly.
  always_comb begin
    for (int r = 0; r < 16; r++) begin
      for (int h = 0; h < 2; h++) begin
        prod[r][h] = act_q[r][input_load_number] * wt[h];
        sum[r][h]  = {{4{prod[r][h][31]}}, prod[r][h]};
        if (input_load_number != 4'd0)
          sum[r][h] = acc_q[r][col[h]] + sum[r][h];
      end
    end
  end

  // Column k is read from registered state, so the k=15 overwrite never disturbs its own read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 16; r++) begin
        for (int c = 0; c < 16; c++) begin
          act_q[r][c] <= '0;
          acc_q[r][c] <= '0;
        end
      end
      beat_j <= '0;
    end else if (act_beat) begin
      act_q[{beat_j, 1'b0}][input_load_number] <= wt[0];
      act_q[{beat_j, 1'b1}][input_load_number] <= wt[1];
      beat_j <= beat_j + 3'd1;
    end else if (weight_beat) begin
      for (int r = 0; r < 16; r++) begin
        for (int h = 0; h < 2; h++) begin
          if (input_load_number == 4'd15)
            act_q[r][col[h]] <= act_fn(sum[r][h]);
          else
            acc_q[r][col[h]] <= sum[r][h];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: cnt_d = '0;
      STREAM: begin
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'd127)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (trigger) begin
      state_d = STREAM;
      cnt_d   = '0;
    end
  end

  always_comb begin
    result_valid_o   = (state_q == STREAM);
    result_payload_o = '0;
    if (state_q == STREAM)
      result_payload_o = {act_q[cnt_q[6:3]][{cnt_q[2:0], 1'b1}],
                          act_q[cnt_q[6:3]][{cnt_q[2:0], 1'b0}]};
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        out_reg_c[r][c] = act_q[r][c];
  end

endmodule

// File: tb/tb_mlp_acc_top.sv
// Directed bench for mlp_acc_top: full eight-layer runs against a plain matrix-product model,
// with readout, gating, saturation and mid-run reset scenarios.
module tb_mlp_acc_top;

  logic                    clk;
  logic                    rst_n;
  logic                    load_en_i;
  logic [31:0]             load_payload_i;
  logic                    load_type_i;
  logic [3:0]              input_load_number;
  logic [2:0]              layer_number;
  logic [2:0]              weight_number;
  logic                    result_valid_o;
  logic [31:0]             result_payload_o;
  logic [15:0][15:0][15:0] out_reg_c;

  mlp_acc_top dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .load_en_i         (load_en_i),
    .load_payload_i    (load_payload_i),
    .load_type_i       (load_type_i),
    .input_load_number (input_load_number),
    .layer_number      (layer_number),
    .weight_number     (weight_number),
    .result_valid_o    (result_valid_o),
    .result_payload_o  (result_payload_o),
    .out_reg_c         (out_reg_c)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int valid_seen = 0;

  int a_m [16][16];
  int w_m [8][16][16];
  int exp_m [16][16];
  logic [31:0] rd [128];
  int rd_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (result_valid_o === 1'b1) valid_seen++;

  initial begin
    #1500000;
    $display("FAIL timeout: simulation exceeded time limit, got running, need finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  function automatic int act_ref(input longint x);
    if (x < 0) return 0;
    if (x > 32767) return 32767;
    return int'(x);
  endfunction

  // Straight row-by-column product per layer.
  task automatic compute_model();
    int cur [16][16];
    longint s;
    cur = a_m;
    for (int l = 0; l < 8; l++) begin
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++) begin
          s = 0;
          for (int k = 0; k < 16; k++) s += longint'(cur[r][k]) * longint'(w_m[l][k][c]);
          exp_m[r][c] = act_ref(s);
        end
      cur = exp_m;
    end
  endtask

  task automatic set_identity_all();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        a_m[r][c] = (r == c) ? 1 : 0;
        for (int l = 0; l < 8; l++) w_m[l][r][c] = (r == c) ? 1 : 0;
      end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    load_en_i = 1'b0;
    load_type_i = 1'b0;
    load_payload_i = '0;
    input_load_number = '0;
    layer_number = '0;
    weight_number = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic beat(input bit en, input bit typ, input int k, input int l, input int w,
                      input logic [31:0] pl);
    load_en_i = en;
    load_type_i = typ;
    input_load_number = 4'(k);
    layer_number = 3'(l);
    weight_number = 3'(w);
    load_payload_i = pl;
    @(posedge clk); #1;
  endtask

  // Drives the whole host sequence; abort_layer >= 0 pulses reset part-way through that layer.
  task automatic run_sequence(input bit en, input int abort_layer);
    logic [31:0] pl;
    for (int l = 0; l < 8; l++)
      for (int k = 0; k < 16; k++) begin
        if (l == abort_layer && k == 4) begin
          load_en_i = 1'b0;
          rst_n = 1'b0;
          @(posedge clk); #1;
          rst_n = 1'b1;
          @(posedge clk); #1;
          return;
        end
        if (l == 0)
          for (int j = 0; j < 8; j++) begin
            pl = en ? {16'(a_m[2*j+1][k]), 16'(a_m[2*j][k])} : $urandom;
            beat(en, 1'b1, k, l, j, pl);
          end
        for (int w = 0; w < 8; w++) begin
          pl = en ? {16'(w_m[l][k][2*w+1]), 16'(w_m[l][k][2*w])} : $urandom;
          beat(en, 1'b0, k, l, w, pl);
        end
      end
    load_en_i = 1'b0;
    load_payload_i = '0;
  endtask

  task automatic capture_readout();
    rd_cnt = 0;
    while (result_valid_o === 1'b1 && rd_cnt < 200) begin
      if (rd_cnt < 128) rd[rd_cnt] = result_payload_o;
      rd_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (result_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b, need 0", result_valid_o);
    end
    n_checks++;
    if (result_payload_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_payload: got %h, need 0", result_payload_o);
    end
    n_checks++;
    if (out_reg_c !== '0) begin
      n_fail++; $display("FAIL reset_out_reg_c: got nonzero, need all 0");
    end
  endtask

  task automatic test_identity();
    set_identity_all();
    run_sequence(1'b1, -1);
    n_checks++;
    if (result_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL ident_valid_rise: got %b, need 1", result_valid_o);
    end
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        n_checks++;
        if (out_reg_c[r][c] !== ((r == c) ? 16'd1 : 16'd0)) begin
          n_fail++;
          $display("FAIL ident_elem[%0d][%0d]: got %0d, need %0d", r, c, out_reg_c[r][c], r == c);
        end
      end
    capture_readout();
    n_checks++;
    if (rd[0] !== 32'h0000_0001) begin
      n_fail++; $display("FAIL ident_beat0: got %h, need 00000001", rd[0]);
    end
    n_checks++;
    if (rd[8] !== 32'h0001_0000) begin
      n_fail++; $display("FAIL ident_beat8: got %h, need 00010000", rd[8]);
    end
    n_checks++;
    if (rd[9] !== 32'h0000_0000) begin
      n_fail++; $display("FAIL ident_beat9: got %h, need 00000000", rd[9]);
    end
    n_checks++;
    if (rd[127] !== 32'h0001_0000) begin
      n_fail++; $display("FAIL ident_beat127: got %h, need 00010000", rd[127]);
    end
    n_checks++;
    if (rd_cnt !== 128) begin
      n_fail++; $display("FAIL ident_valid_len: got %0d, need 128", rd_cnt);
    end
    n_checks++;
    if (result_payload_o !== 32'h0) begin
      n_fail++; $display("FAIL ident_idle_payload: got %h, need 0", result_payload_o);
    end
  endtask

  task automatic test_relu();
    set_identity_all();
    a_m[0][0] = -5;
    run_sequence(1'b1, -1);
    for (int r = 0; r < 16; r++) begin
      n_checks++;
      if (out_reg_c[r][r] !== ((r == 0) ? 16'd0 : 16'd1)) begin
        n_fail++;
        $display("FAIL relu_diag[%0d]: got %0d, need %0d", r, out_reg_c[r][r], r != 0);
      end
    end
    n_checks++;
    if (out_reg_c[0][1] !== 16'd0) begin
      n_fail++; $display("FAIL relu_offdiag: got %0d, need 0", out_reg_c[0][1]);
    end
    capture_readout();
  endtask

  task automatic test_saturate();
    set_identity_all();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        a_m[r][c] = 200;
        w_m[0][r][c] = 200;
      end
    run_sequence(1'b1, -1);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        n_checks++;
        if (out_reg_c[r][c] !== 16'd32767) begin
          n_fail++;
          $display("FAIL sat_elem[%0d][%0d]: got %0d, need 32767", r, c, out_reg_c[r][c]);
        end
      end
    capture_readout();
    n_checks++;
    if (rd[37] !== 32'h7FFF_7FFF) begin
      n_fail++; $display("FAIL sat_beat37: got %h, need 7fff7fff", rd[37]);
    end
  endtask

  task automatic test_random();
    int v0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        a_m[r][c] = int'($urandom_range(15)) - 8;
        for (int l = 0; l < 8; l++) w_m[l][r][c] = int'($urandom_range(15)) - 8;
      end
    compute_model();
    v0 = valid_seen;
    run_sequence(1'b1, -1);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        n_checks++;
        if (out_reg_c[r][c] !== 16'(exp_m[r][c])) begin
          n_fail++;
          $display("FAIL rand_elem[%0d][%0d]: got %0d, need %0d", r, c, out_reg_c[r][c], exp_m[r][c]);
        end
      end
    capture_readout();
    for (int n = 0; n < 128; n++) begin
      n_checks++;
      if (rd[n] !== {16'(exp_m[n/8][2*(n%8)+1]), 16'(exp_m[n/8][2*(n%8)])}) begin
        n_fail++;
        $display("FAIL rand_beat[%0d]: got %h, need %h", n, rd[n],
                 {16'(exp_m[n/8][2*(n%8)+1]), 16'(exp_m[n/8][2*(n%8)])});
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (valid_seen - v0 !== 128) begin
      n_fail++; $display("FAIL rand_valid_cycles: got %0d, need 128", valid_seen - v0);
    end
  endtask

  task automatic test_load_disabled();
    int v0;
    apply_reset();
    v0 = valid_seen;
    run_sequence(1'b0, -1);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_reg_c !== '0) begin
      n_fail++; $display("FAIL dis_out_reg_c: got nonzero, need all 0");
    end
    n_checks++;
    if (valid_seen - v0 !== 0) begin
      n_fail++; $display("FAIL dis_valid: got %0d valid cycles, need 0", valid_seen - v0);
    end
  endtask

  task automatic test_reset_midrun();
    run_sequence(1'b1, 3);
    n_checks++;
    if (out_reg_c !== '0) begin
      n_fail++; $display("FAIL mid_rst_clear: got nonzero, need all 0");
    end
    run_sequence(1'b1, -1);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        n_checks++;
        if (out_reg_c[r][c] !== 16'(exp_m[r][c])) begin
          n_fail++;
          $display("FAIL mid_elem[%0d][%0d]: got %0d, need %0d", r, c, out_reg_c[r][c], exp_m[r][c]);
        end
      end
    capture_readout();
    n_checks++;
    if (rd_cnt !== 128) begin
      n_fail++; $display("FAIL mid_valid_len: got %0d, need 128", rd_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_relu();
    test_saturate();
    test_random();
    test_reset_midrun();
    test_load_disabled();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
